ber_sync_counter: RTL and testbench

Parametrised bit-error-rate checker for one demodulated bit stream (one instance per I/Q channel). It compares received bits against the local PRBS reference and first sweeps every candidate delay to find the alignment with the fewest mismatches. It then locks to that phase and accumulates saturating bit and error counts. Unlike the earlier fixed I/Q checkers, it monitors errors per window while locked and re-enters the search automatically on loss of lock. It sits after the slicer/decimator, beside the PRBS generator, and feeds the register bank read by the soft processor.

---
 rtl/ber_sync_counter_if.sv | 26 ++
 rtl/ber_sync_counter.sv | 127 ++++++++++++
 tb/tb_ber_sync_counter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ber_sync_counter_if.sv
// Stream and status bundle between the demod bit path and the BER checker.
interface ber_sync_counter_if #(
    parameter int PH_W  = 10,
    parameter int CNT_W = 64
) ();
    logic             i_enable;
    logic             i_valid;
    logic             i_rx;
    logic             i_ref;
    logic             i_clear;
    logic             o_locked;
    logic [PH_W-1:0]  o_phase;
    logic             o_lost;
    logic [CNT_W-1:0] o_bits;
    logic [CNT_W-1:0] o_errors;

    modport master (
        output i_enable, i_valid, i_rx, i_ref, i_clear,
        input  o_locked, o_phase, o_lost, o_bits, o_errors
    );

    modport slave (
        input  i_enable, i_valid, i_rx, i_ref, i_clear,
        output o_locked, o_phase, o_lost, o_bits, o_errors
    );
endinterface

// File: rtl/ber_sync_counter.sv
// BER checker: sweeps every reference delay for the fewest mismatches, locks to it,
// accumulates saturating bit/error counts and re-searches when a window errs too much.
module ber_sync_counter #(
    parameter int DEPTH   = 1024,
    parameter int WIN     = 511,
    parameter int CNT_W   = 64,
    parameter int LOSS_TH = 64
) (
    input logic               clock,
    input logic               i_reset,
    ber_sync_counter_if.slave bus
);
    localparam int PH_W = $clog2(DEPTH);
    localparam int WC_W = $clog2(WIN + 2);
    localparam int SC_W = (WIN > 1) ? $clog2(WIN) : 1;

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state_q;
    logic [DEPTH-1:0] dly_q;
    logic [PH_W-1:0]  trial_q;
    logic [PH_W-1:0]  best_ph_q;
    logic [PH_W-1:0]  phase_q;
    logic [SC_W-1:0]  sc_q;
    logic [WC_W-1:0]  wc_q;
    logic [WC_W-1:0]  best_q;
    logic             locked_q;
    logic             lost_q;
    logic [CNT_W-1:0] bits_q;
    logic [CNT_W-1:0] errs_q;

    logic             accept;
    logic             mis;
    logic             win_end;
    logic             last_trial;
    logic             better;
    logic [PH_W-1:0]  sel;
    logic [WC_W-1:0]  wc_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                 input logic inc);
        if (inc && (&cnt)) return cnt;
        return cnt + CNT_W'(inc);
    endfunction

    always_comb begin
        accept     = bus.i_enable && bus.i_valid;
        sel        = (state_q == LOCKED) ? phase_q : trial_q;
        mis        = bus.i_rx ^ dly_q[sel];
        wc_d       = wc_q + WC_W'(mis);
        win_end    = (sc_q == SC_W'(WIN - 1));
        last_trial = (trial_q == PH_W'(DEPTH - 1));
        better     = (wc_d < best_q);
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q   <= SEARCH;
            dly_q     <= '0;
            trial_q   <= '0;
            best_ph_q <= '0;
            phase_q   <= '0;
            sc_q      <= '0;
            wc_q      <= '0;
            best_q    <= WC_W'(WIN + 1);
            locked_q  <= 1'b0;
            lost_q    <= 1'b0;
            bits_q    <= '0;
            errs_q    <= '0;
        end else begin
            // The loss pulse is one cycle wide even if the block is frozen right after it.
            lost_q <= 1'b0;
            if (bus.i_enable) begin
                if (bus.i_clear) begin
                    bits_q <= '0;
                    errs_q <= '0;
                end else if (accept && state_q == LOCKED) begin
                    bits_q <= sat_inc(bits_q, 1'b1);
                    errs_q <= sat_inc(errs_q, mis);
                end

                if (accept) begin
                    dly_q <= {dly_q[DEPTH-2:0], bus.i_ref};
                    sc_q  <= win_end ? '0 : sc_q + SC_W'(1);
                    wc_q  <= win_end ? '0 : wc_d;

                    case (state_q)
                        SEARCH: begin
                            if (win_end) begin
                                if (last_trial) begin
                                    // Strict compare keeps the lower phase on a tie.
                                    phase_q  <= better ? trial_q : best_ph_q;
                                    state_q  <= LOCKED;
                                    locked_q <= 1'b1;
                                    trial_q  <= '0;
                                    best_q   <= WC_W'(WIN + 1);
                                end else begin
                                    if (better) begin
                                        best_q    <= wc_d;
                                        best_ph_q <= trial_q;
                                    end
                                    trial_q <= trial_q + PH_W'(1);
                                end
                            end
                        end
                        LOCKED: begin
                            if (win_end && wc_d >= WC_W'(LOSS_TH)) begin
                                state_q  <= SEARCH;
                                locked_q <= 1'b0;
                                lost_q   <= 1'b1;
                                trial_q  <= '0;
                                best_q   <= WC_W'(WIN + 1);
                            end
                        end
                        default: state_q <= SEARCH;
                    endcase
                end
            end
        end
    end

    assign bus.o_locked = locked_q;
    assign bus.o_phase  = phase_q;
    assign bus.o_lost   = lost_q;
    assign bus.o_bits   = bits_q;
    assign bus.o_errors = errs_q;
endmodule

// File: tb/tb_ber_sync_counter.sv
// Directed bench: PRBS7 reference, delayed received stream, two instances
// (wide counters / LOSS_TH=8 and 8-bit counters / LOSS_TH=WIN=31).
module tb_ber_sync_counter;
    localparam int PH_W = 6;

    logic clock = 1'b0;
    logic i_reset = 1'b1;
    always #5 clock = ~clock;

    ber_sync_counter_if #(.PH_W(PH_W), .CNT_W(16)) bus_a ();
    ber_sync_counter_if #(.PH_W(PH_W), .CNT_W(8))  bus_s ();

    ber_sync_counter #(.DEPTH(64), .WIN(31), .CNT_W(16), .LOSS_TH(8)) dut_a (
        .clock(clock), .i_reset(i_reset), .bus(bus_a.slave));
    ber_sync_counter #(.DEPTH(64), .WIN(31), .CNT_W(8), .LOSS_TH(31)) dut_s (
        .clock(clock), .i_reset(i_reset), .bus(bus_s.slave));

    logic en, vld, refb, rxa, rxs, clr;
    assign bus_a.i_enable = en;
    assign bus_a.i_valid  = vld;
    assign bus_a.i_ref    = refb;
    assign bus_a.i_rx     = rxa;
    assign bus_a.i_clear  = clr;
    assign bus_s.i_enable = en;
    assign bus_s.i_valid  = vld;
    assign bus_s.i_ref    = refb;
    assign bus_s.i_rx     = rxs;
    assign bus_s.i_clear  = clr;

    int total = 0;
    int bad = 0;
    int lost_a_cnt = 0;
    int lost_s_cnt = 0;
    logic [6:0]   lfsr = 7'h7F;
    logic [127:0] hist = '0;
    int dly_a = 37;
    int flip_per = 0;
    int fcnt = 0;
    int sat_mode = 0;
    bit a_lk = 1'b0;
    bit s_lk = 1'b0;
    int lk_a = 0;
    int lk_s = 0;

    always @(posedge clock) begin
        if (bus_a.o_lost) lost_a_cnt <= lost_a_cnt + 1;
        if (bus_s.o_lost) lost_s_cnt <= lost_s_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One cycle; when v is set, one accepted sample of the PRBS7 stream.
    task automatic send1(input logic v);
        logic nb;
        logic fl;
        en  = 1'b1;
        vld = v;
        nb  = lfsr[6] ^ lfsr[5];
        if (v) begin
            fl   = (flip_per != 0) && (fcnt % flip_per == flip_per - 1);
            refb = nb;
            rxa  = hist[dly_a-1] ^ fl;
            case (sat_mode)
                0:       rxs = rxa;
                1:       rxs = hist[36] ^ (lk_s % 31 != 0);
                2:       rxs = ~hist[36];
                default: rxs = hist[36];
            endcase
        end else begin
            refb = 1'($urandom);
            rxa  = 1'($urandom);
            rxs  = 1'($urandom);
        end
        tick();
        if (v) begin
            lfsr = {lfsr[5:0], nb};
            hist = {hist[126:0], nb};
            fcnt++;
            if (a_lk) lk_a++;
            if (s_lk) lk_s++;
        end
    endtask

    task automatic freeze(input int n);
        en  = 1'b0;
        vld = 1'b1;
        clr = 1'b1;
        for (int i = 0; i < n; i++) begin
            rxa = 1'($urandom);
            rxs = ~rxa;
            tick();
        end
        clr = 1'b0;
        en  = 1'b1;
    endtask

    initial begin
        int exp_bits;
        int exp_err;
        int wcm;
        int srch;
        bit got;
        logic m;
        en = 1'b0; vld = 1'b0; refb = 1'b0; rxa = 1'b0; rxs = 1'b0; clr = 1'b0;

        tick();
        tick();
        chk("rst_locked", bus_a.o_locked, 0);
        chk("rst_phase", bus_a.o_phase, 0);
        chk("rst_lost", bus_a.o_lost, 0);
        chk("rst_bits", bus_a.o_bits, 0);
        chk("rst_errors", bus_a.o_errors, 0);
        i_reset = 1'b0;

        // Reset in the middle of trial phase 20.
        repeat (630) send1(1'b1);
        chk("p20_unlocked", bus_a.o_locked, 0);
        i_reset = 1'b1;
        send1(1'b1);
        i_reset = 1'b0;
        chk("mid_rst_locked", bus_a.o_locked, 0);
        chk("mid_rst_phase", bus_a.o_phase, 0);
        chk("mid_rst_bits", bus_a.o_bits, 0);

        // Full sweep restarts; a frozen stretch mid-window must not shift lock timing.
        repeat (1000) send1(1'b1);
        freeze(50);
        repeat (983) send1(1'b1);
        chk("pre_lock", bus_a.o_locked, 0);
        send1(1'b1);
        chk("lock_a", bus_a.o_locked, 1);
        chk("phase_a", bus_a.o_phase, 36);
        chk("lock_s", bus_s.o_locked, 1);
        chk("phase_s", bus_s.o_phase, 36);
        a_lk = 1'b1;
        s_lk = 1'b1;

        repeat (5000) send1(1'b1);
        chk("clean_bits", bus_a.o_bits, 5000);
        chk("clean_errors", bus_a.o_errors, 0);
        chk("sat_bits_clean", bus_s.o_bits, 255);
        chk("sat_errs_clean", bus_s.o_errors, 0);

        freeze(50);
        chk("frz_bits", bus_a.o_bits, 5000);
        chk("frz_errors", bus_a.o_errors, 0);
        chk("frz_locked", bus_a.o_locked, 1);

        // Clear together with an accepted erroring sample.
        flip_per = 1; fcnt = 0; clr = 1'b1;
        send1(1'b1);
        clr = 1'b0; flip_per = 0;
        chk("clr_bits", bus_a.o_bits, 0);
        chk("clr_errors", bus_a.o_errors, 0);
        chk("clr_errs_s", bus_s.o_errors, 0);

        // Valid every other cycle, one flip per 100 accepted samples.
        flip_per = 100; fcnt = 0;
        for (int i = 0; i < 10000; i++) begin
            send1(1'b1);
            send1(1'b0);
        end
        flip_per = 0;
        chk("flip_bits", bus_a.o_bits, 10000);
        chk("flip_errors", bus_a.o_errors, 100);
        chk("flip_no_lost", lost_a_cnt, 0);
        chk("flip_locked", bus_a.o_locked, 1);
        chk("flip_errs_s", bus_s.o_errors, 100);

        // Align to a monitor window boundary, then move the delay to 10.
        exp_bits = 10000;
        while (lk_a % 31 != 0) begin
            send1(1'b1);
            exp_bits++;
        end
        dly_a = 10; sat_mode = 3;
        exp_err = 100; wcm = 0; got = 1'b0;
        for (int i = 0; i < 124 && !got; i++) begin
            m = hist[9] ^ hist[36];
            send1(1'b1);
            exp_bits++;
            exp_err += int'(m);
            wcm += int'(m);
            if (lk_a % 31 == 0) begin
                if (wcm >= 8) got = 1'b1;
                wcm = 0;
            end
        end
        a_lk = 1'b0;
        chk("lost_pulse", bus_a.o_lost, 1);
        chk("lost_unlocked", bus_a.o_locked, 0);
        chk("loss_bits", bus_a.o_bits, 64'(exp_bits));
        chk("loss_errors", bus_a.o_errors, 64'(exp_err));
        send1(1'b1);
        srch = 1;
        chk("lost_one_cycle", bus_a.o_lost, 0);
        chk("lost_count", lost_a_cnt, 1);

        // Saturation on the 8-bit instance while the wide one re-sweeps.
        while (lk_s % 31 != 0) begin
            send1(1'b1);
            srch++;
        end
        sat_mode = 1;
        repeat (310) begin
            send1(1'b1);
            srch++;
        end
        chk("sat_errors", bus_s.o_errors, 255);
        chk("sat_bits", bus_s.o_bits, 255);
        chk("sat_no_lost", lost_s_cnt, 0);
        sat_mode = 2;
        repeat (30) begin
            send1(1'b1);
            srch++;
        end
        chk("sat_still_locked", bus_s.o_locked, 1);
        send1(1'b1);
        srch++;
        chk("sat_lost", bus_s.o_lost, 1);
        chk("sat_unlocked", bus_s.o_locked, 0);
        s_lk = 1'b0; sat_mode = 3;
        send1(1'b1);
        srch++;
        chk("sat_hold_bits", bus_s.o_bits, 255);
        chk("sat_hold_errors", bus_s.o_errors, 255);

        while (srch < 1983) begin
            send1(1'b1);
            srch++;
        end
        chk("relock_pending", bus_a.o_locked, 0);
        chk("srch_hold_bits", bus_a.o_bits, 64'(exp_bits));
        chk("srch_hold_errors", bus_a.o_errors, 64'(exp_err));
        send1(1'b1);
        chk("relock", bus_a.o_locked, 1);
        chk("relock_phase", bus_a.o_phase, 9);
        chk("relock_bits", bus_a.o_bits, 64'(exp_bits));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
